// File: rtl/fp_identify_ctrl.sv
// fp_identify_ctrl
// Sequences the fingerprint module's identify (0x11) transaction over the
// shared byte UART. It sends the fixed 12-byte command packet one byte at a
// time, then collects and validates the 16-byte response. One result pulse
// (match / no-match / frame error / timeout) is produced per transaction.
// The transaction repeats every POLL_CYCLES while i_start is held high.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start                   level enable for polling
//   o_tx_data, o_tx_en        command byte and one-cycle send request to UART TX
//   i_tx_done                 one-cycle pulse, UART TX finished the byte
//   i_rx_data, i_rx_valid     received byte and its one-cycle strobe
//   o_busy                    high while a transaction is in flight
//   o_match_ok, o_match_fail  result pulses (confirm == 0 / confirm != 0)
//   o_frame_err, o_timeout    result pulses (bad frame / response too slow)
//   o_page_id, o_score        latched on o_match_ok only
//   o_confirm                 latched on o_match_ok or o_match_fail
module fp_identify_ctrl #(
  parameter int POLL_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_en,
  input  logic        i_tx_done,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_busy,
  output logic        o_match_ok,
  output logic        o_match_fail,
  output logic        o_frame_err,
  output logic        o_timeout,
  output logic [15:0] o_page_id,
  output logic [15:0] o_score,
  output logic [7:0]  o_confirm
);

  // One counter serves both the RECV timeout and the WAIT poll interval;
  // 27 bits covers terminal counts up to 2^26.
  localparam int CNT_W = 27;
  localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_RECV  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  function automatic logic [7:0] cmd_byte(input logic [3:0] idx);
    case (idx)
      4'd0:                    cmd_byte = 8'hEF;
      4'd1, 4'd6:              cmd_byte = 8'h01;
      4'd2, 4'd3, 4'd4, 4'd5:  cmd_byte = 8'hFF;
      4'd8:                    cmd_byte = 8'h03;
      4'd9:                    cmd_byte = 8'h11;
      4'd11:                   cmd_byte = 8'h15;
      default:                 cmd_byte = 8'h00;
    endcase
  endfunction

  // Fixed part of the response (bytes 0..8).
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
    case (idx)
      4'd0:                    hdr_byte = 8'hEF;
      4'd1:                    hdr_byte = 8'h01;
      4'd2, 4'd3, 4'd4, 4'd5:  hdr_byte = 8'hFF;
      4'd6, 4'd8:              hdr_byte = 8'h07;
      default:                 hdr_byte = 8'h00;
    endcase
  endfunction

  logic [2:0]       r_state;
  logic [3:0]       r_tx_idx;
  logic             r_tx_pend;
  logic             r_tx_en;
  logic [7:0]       r_tx_data;
  logic [3:0]       r_rx_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_sum;
  logic [7:0]       r_conf_b;
  logic [15:0]      r_page_b;
  logic [15:0]      r_score_b;
  logic [15:0]      r_rsum_b;
  logic             r_match_ok;
  logic             r_match_fail;
  logic             r_frame_err;
  logic             r_timeout;
  logic [15:0]      r_page_id;
  logic [15:0]      r_score;
  logic [7:0]       r_confirm;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_tx_idx     <= '0;
      r_tx_pend    <= 1'b0;
      r_tx_en      <= 1'b0;
      r_tx_data    <= '0;
      r_rx_idx     <= '0;
      r_cnt        <= '0;
      r_sum        <= '0;
      r_conf_b     <= '0;
      r_page_b     <= '0;
      r_score_b    <= '0;
      r_rsum_b     <= '0;
      r_match_ok   <= 1'b0;
      r_match_fail <= 1'b0;
      r_frame_err  <= 1'b0;
      r_timeout    <= 1'b0;
      r_page_id    <= '0;
      r_score      <= '0;
      r_confirm    <= '0;
    end else begin
      r_tx_en      <= 1'b0;
      r_match_ok   <= 1'b0;
      r_match_fail <= 1'b0;
      r_frame_err  <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_SEND;
            r_tx_idx  <= '0;
            r_tx_pend <= 1'b1;
          end
        end
        S_SEND: begin
          // r_tx_pend marks entry into SEND: the first byte is requested one
          // cycle after entry; later bytes go out the cycle after tx_done.
          if (r_tx_pend) begin
            r_tx_pend <= 1'b0;
            r_tx_en   <= 1'b1;
            r_tx_data <= cmd_byte(r_tx_idx);
          end else if (i_tx_done) begin
            if (r_tx_idx == 4'd11) begin
              r_state  <= S_RECV;
              r_rx_idx <= '0;
              r_cnt    <= '0;
              r_sum    <= '0;
            end else begin
              r_tx_idx  <= r_tx_idx + 4'd1;
              r_tx_en   <= 1'b1;
              r_tx_data <= cmd_byte(r_tx_idx + 4'd1);
            end
          end
        end
        S_RECV: begin
          // A byte arriving on the terminal-count cycle takes priority.
          if (i_rx_valid) begin
            r_cnt    <= '0;
            r_rx_idx <= r_rx_idx + 4'd1;
            if ((r_rx_idx <= 4'd8) && (i_rx_data != hdr_byte(r_rx_idx))) begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT;
            end else begin
              if ((r_rx_idx >= 4'd6) && (r_rx_idx <= 4'd13))
                r_sum <= r_sum + {8'h00, i_rx_data};
              case (r_rx_idx)
                4'd9:    r_conf_b        <= i_rx_data;
                4'd10:   r_page_b[15:8]  <= i_rx_data;
                4'd11:   r_page_b[7:0]   <= i_rx_data;
                4'd12:   r_score_b[15:8] <= i_rx_data;
                4'd13:   r_score_b[7:0]  <= i_rx_data;
                4'd14:   r_rsum_b[15:8]  <= i_rx_data;
                4'd15:   r_rsum_b[7:0]   <= i_rx_data;
                default: ;
              endcase
              if (r_rx_idx == 4'd15)
                r_state <= S_CHECK;
            end
          end else if (r_cnt == TMO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_WAIT;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          r_state <= S_WAIT;
          r_cnt   <= '0;
          if (r_rsum_b != r_sum) begin
            r_frame_err <= 1'b1;
          end else if (r_conf_b == 8'h00) begin
            r_match_ok <= 1'b1;
            r_page_id  <= r_page_b;
            r_score    <= r_score_b;
            r_confirm  <= r_conf_b;
          end else begin
            r_match_fail <= 1'b1;
            r_confirm    <= r_conf_b;
          end
        end
        S_WAIT: begin
          if (!i_start) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == POLL_LAST) begin
            r_state   <= S_SEND;
            r_tx_idx  <= '0;
            r_tx_pend <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_data    = r_tx_data;
  assign o_tx_en      = r_tx_en;
  assign o_busy       = (r_state == S_SEND) || (r_state == S_RECV) || (r_state == S_CHECK);
  assign o_match_ok   = r_match_ok;
  assign o_match_fail = r_match_fail;
  assign o_frame_err  = r_frame_err;
  assign o_timeout    = r_timeout;
  assign o_page_id    = r_page_id;
  assign o_score      = r_score;
  assign o_confirm    = r_confirm;

endmodule

// File: tb/tb_fp_identify_ctrl.sv
// Directed testbench for fp_identify_ctrl with POLL_CYCLES=100 and
// TIMEOUT_CYCLES=50. A UART TX model answers each tx_en with tx_done ten
// cycles later; responses are driven byte by byte with chosen spacing.
module tb_fp_identify_ctrl;
  localparam int POLL = 100;
  localparam int TMO  = 50;

  typedef logic [15:0][7:0] resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tx_done = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        busy;
  logic        match_ok;
  logic        match_fail;
  logic        frame_err;
  logic        tmo;
  logic [15:0] page_id;
  logic [15:0] score;
  logic [7:0]  confirm;

  fp_identify_ctrl #(.POLL_CYCLES(POLL), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .o_tx_data(tx_data), .o_tx_en(tx_en), .i_tx_done(tx_done),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_busy(busy),
    .o_match_ok(match_ok), .o_match_fail(match_fail),
    .o_frame_err(frame_err), .o_timeout(tmo),
    .o_page_id(page_id), .o_score(score), .o_confirm(confirm)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Cycle bookkeeping: cyc is the index of the cycle that the next posedge ends.
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;
  int done_cyc_q[$];

  always @(posedge clk) begin
    if (tx_done) begin
      done_cnt++;
      last_done_cyc = cyc;
      done_cyc_q.push_back(cyc);
    end
    cyc++;
  end

  // Output monitor, sampled mid-cycle.
  logic [7:0] tx_log[$];
  int txen_cyc_q[$];
  int txen_cnt = 0;
  int viol = 0;
  int n_ok = 0, n_fail = 0, n_ferr = 0, n_tmo = 0;
  int last_res_cyc = -1;

  always @(negedge clk) begin
    if (!rst_n) begin
      txen_cnt = done_cnt;
    end else begin
      if (tx_en) begin
        if (!busy || (txen_cnt != done_cnt)) viol++;
        txen_cnt++;
        tx_log.push_back(tx_data);
        txen_cyc_q.push_back(cyc);
      end
      if (match_ok)   begin n_ok++;   last_res_cyc = cyc; end
      if (match_fail) begin n_fail++; last_res_cyc = cyc; end
      if (frame_err)  begin n_ferr++; last_res_cyc = cyc; end
      if (tmo)        begin n_tmo++;  last_res_cyc = cyc; end
    end
  end

  // UART TX model: tx_done ten cycles after each tx_en, abandoned on reset.
  initial begin
    bit ab;
    forever begin
      @(negedge clk);
      while (tx_en && rst_n) begin
        ab = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            ab = 1'b1;
            break;
          end
        end
        if (!ab) begin
          tx_done = 1'b1;
          @(negedge clk);
          tx_done = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cmd(input int target, output int m);
    int t;
    t = 0;
    while (done_cnt < target && t < 1500) begin
      @(negedge clk);
      t++;
    end
    check_val("cmd_complete", done_cnt, target);
    m = last_done_cyc;
  endtask

  // Byte i is driven in cycle first_at + i*gap; start drops before byte drop_idx.
  task automatic send_resp(input resp_t r, input int first_at, input int gap,
                           input int drop_idx, output int k_last);
    while (cyc < first_at) @(negedge clk);
    k_last = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == drop_idx) start = 1'b0;
      rx_data  = r[i];
      rx_valid = 1'b1;
      k_last   = cyc;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      if (i < 15) tick(gap - 1);
    end
  endtask

  function automatic resp_t mk_resp(input logic [7:0] conf, input logic [15:0] page,
                                    input logic [15:0] scr, input logic [15:0] sum);
    resp_t r;
    r[0] = 8'hEF; r[1] = 8'h01; r[2] = 8'hFF; r[3] = 8'hFF;
    r[4] = 8'hFF; r[5] = 8'hFF; r[6] = 8'h07; r[7] = 8'h00;
    r[8] = 8'h07; r[9] = conf;
    r[10] = page[15:8]; r[11] = page[7:0];
    r[12] = scr[15:8];  r[13] = scr[7:0];
    r[14] = sum[15:8];  r[15] = sum[7:0];
    return r;
  endfunction

  logic [7:0] cmd_ref [12] = '{8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                               8'h01, 8'h00, 8'h03, 8'h11, 8'h00, 8'h15};

  initial begin
    int n0, m, k, f, bad, base, t, tot;
    resp_t r_nom, r_nomatch, r_b6, r_badsum;
    // Bytes 6..13 of the nominal frame: 07+00+07+00+00+05+00+3C = 0x004F.
    r_nom     = mk_resp(8'h00, 16'h0005, 16'h003C, 16'h004F);
    // 07+00+07+09 = 0x0017.
    r_nomatch = mk_resp(8'h09, 16'h0000, 16'h0000, 16'h0017);
    r_b6      = r_nom;
    r_b6[6]   = 8'h01;
    r_badsum  = mk_resp(8'h00, 16'h0005, 16'h003C, 16'h0056);

    // Reset state
    tick(3);
    check_val("rst_tx_en", tx_en, 0);
    check_val("rst_tx_data", tx_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_pulses", {match_ok, match_fail, frame_err, tmo}, 0);
    check_val("rst_page", page_id, 0);
    check_val("rst_score", score, 0);
    check_val("rst_confirm", confirm, 0);
    rst_n = 1'b1;
    tick(2);

    // Transaction 1: nominal match
    start = 1'b1;
    n0 = cyc;
    wait_cmd(12, m);
    check_val("first_txen_cycle", txen_cyc_q[0], n0 + 2);
    for (int i = 0; i < 12; i++)
      check_val($sformatf("cmd_byte%0d", i), tx_log[i], cmd_ref[i]);
    bad = 0;
    for (int i = 1; i < 12; i++)
      if (txen_cyc_q[i] != done_cyc_q[i-1] + 1) bad++;
    check_val("txen_after_done", bad, 0);
    send_resp(r_nom, m + 3, 2, -1, k);
    tick(4);
    check_val("t1_ok_cnt", n_ok, 1);
    check_val("t1_res_cycle", last_res_cyc, k + 2);
    check_val("t1_page", page_id, 16'h0005);
    check_val("t1_score", score, 16'h003C);
    check_val("t1_confirm", confirm, 8'h00);

    // Transaction 2: no match, after one poll interval
    wait_cmd(24, m);
    check_val("t2_poll_txen", txen_cyc_q[12], k + 103);
    send_resp(r_nomatch, m + 3, 2, -1, k);
    tick(4);
    check_val("t2_fail_cnt", n_fail, 1);
    check_val("t2_res_cycle", last_res_cyc, k + 2);
    check_val("t2_confirm", confirm, 8'h09);
    check_val("t2_page_kept", page_id, 16'h0005);
    check_val("t2_score_kept", score, 16'h003C);

    // Transaction 3: corrupt byte 6
    wait_cmd(36, m);
    f = m + 3;
    send_resp(r_b6, f, 2, -1, k);
    tick(4);
    check_val("t3_ferr_cnt", n_ferr, 1);
    check_val("t3_ferr_cycle", last_res_cyc, f + 13);
    check_val("t3_other_results", n_ok + n_fail + n_tmo, 2);
    wait_cmd(48, m);
    check_val("t3_next_txen", txen_cyc_q[36], f + 114);

    // Transaction 4: bad checksum
    send_resp(r_badsum, m + 3, 2, -1, k);
    tick(4);
    check_val("t4_ferr_cnt", n_ferr, 2);
    check_val("t4_ferr_cycle", last_res_cyc, k + 2);
    check_val("t4_confirm_kept", confirm, 8'h09);

    // Transaction 5: silence
    wait_cmd(60, m);
    while (cyc < m + 60) @(negedge clk);
    check_val("t5_tmo_cnt", n_tmo, 1);
    check_val("t5_tmo_cycle", last_res_cyc, m + 51);
    check_val("t5_busy", busy, 0);

    // Transaction 6: one byte every 40 cycles
    wait_cmd(72, m);
    send_resp(r_nom, m + 40, 40, -1, k);
    tick(4);
    check_val("t6_tmo_cnt", n_tmo, 1);
    check_val("t6_ok_cnt", n_ok, 2);
    check_val("t6_res_cycle", last_res_cyc, k + 2);

    // Transaction 7: every byte lands on the terminal-count cycle
    wait_cmd(84, m);
    send_resp(r_nom, m + 50, 50, -1, k);
    tick(4);
    check_val("t7_tmo_cnt", n_tmo, 1);
    check_val("t7_ok_cnt", n_ok, 3);

    // Transaction 8: start dropped mid-RECV
    wait_cmd(96, m);
    send_resp(r_nom, m + 3, 2, 5, k);
    tick(4);
    check_val("t8_ok_cnt", n_ok, 4);
    check_val("t8_res_cycle", last_res_cyc, k + 2);
    tick(150);
    check_val("t8_idle_no_txen", tx_log.size(), 96);
    check_val("t8_idle_busy", busy, 0);

    // Reset during SEND byte 4
    start = 1'b1;
    t = 0;
    while (tx_log.size() < 101 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_val("rst_reach_byte4", tx_log.size(), 101);
    tick(2);
    tot = n_ok + n_fail + n_ferr + n_tmo;
    rst_n = 1'b0;
    tick(1);
    check_val("mid_rst_tx_en", tx_en, 0);
    check_val("mid_rst_tx_data", tx_data, 0);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_page", page_id, 0);
    check_val("mid_rst_score", score, 0);
    check_val("mid_rst_confirm", confirm, 0);
    tick(3);
    rst_n = 1'b1;
    base = tx_log.size();
    t = 0;
    while (tx_log.size() <= base && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_val("restart_txen", tx_log.size(), base + 1);
    if (tx_log.size() > base)
      check_val("restart_byte0", tx_log[base], 8'hEF);
    check_val("rst_no_result", n_ok + n_fail + n_ferr + n_tmo, tot);
    check_val("txen_protocol", viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
